// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: shared CPU encodings for next-PC selection, exception entry and redirect FSM
package pc_redirect_ctrl_pkg;
  typedef enum logic [2:0] {
    SEL_PC4     = 3'd0,
    SEL_TARGET  = 3'd1,
    SEL_CORRECT = 3'd2,
    SEL_EPC     = 3'd3,
    SEL_MEMPC   = 3'd4,
    SEL_EXCEPT  = 3'd5
  } pc_sel_e;
  typedef enum logic [1:0] {
    EX_NONE    = 2'd0,
    EX_ERET    = 2'd1,
    EX_REFETCH = 2'd2,
    EX_EXCEPT  = 2'd3
  } ex_entry_e;
  typedef enum logic {IDLE, HOLD} state_e;
  localparam int NUM_PERF = 5;
  function automatic logic [2:0] sel_rank(pc_sel_e s);
    return s == SEL_EXCEPT  ? 3'd5 :
           s == SEL_EPC     ? 3'd4 :
           s == SEL_MEMPC   ? 3'd3 :
           s == SEL_CORRECT ? 3'd2 :
           s == SEL_TARGET  ? 3'd1 : 3'd0;
  endfunction
  function automatic logic is_redirect(pc_sel_e s);
    return s >= SEL_CORRECT;
  endfunction
endpackage

// File: rtl/pc_redirect_ctrl_prio_enc.sv
// pc_prio_enc: fixed-priority resolution of live next-PC requests into a class and address
// ports: cur_pc, bpu_valid/bpu_target, pred_fail/correct_pc, ex_entry_sel, epc, mem_pc, except_vec in; sel, addr out
module pc_prio_enc
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [31:0] cur_pc,
  input  logic        bpu_valid,
  input  logic [31:0] bpu_target,
  input  logic        pred_fail,
  input  logic [31:0] correct_pc,
  input  logic [1:0]  ex_entry_sel,
  input  logic [31:0] epc,
  input  logic [31:0] mem_pc,
  input  logic [31:0] except_vec,
  output pc_sel_e     sel,
  output logic [31:0] addr
);
  always_comb begin
    sel = ex_entry_sel == EX_EXCEPT  ? SEL_EXCEPT  :
          ex_entry_sel == EX_ERET    ? SEL_EPC     :
          ex_entry_sel == EX_REFETCH ? SEL_MEMPC   :
          pred_fail                  ? SEL_CORRECT :
          bpu_valid                  ? SEL_TARGET  : SEL_PC4;
    addr = sel == SEL_EXCEPT  ? except_vec :
           sel == SEL_EPC     ? epc        :
           sel == SEL_MEMPC   ? mem_pc     :
           sel == SEL_CORRECT ? correct_pc :
           sel == SEL_TARGET  ? bpu_target : cur_pc + 32'd4;
  end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-PC selection with a held redirect while fetch is stalled
// ports: clk, rst, pc_ready, cur_pc, bpu_*, pred_fail/correct_pc, ex_entry_sel/epc/mem_pc/except_vec in;
//        pc_sel, next_pc, pc_we, flush_if, pending out; perf_cnt out when REDIRECT_PERF_CNT_EN is defined
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_ready,
  input  logic [31:0] cur_pc,
  input  logic        bpu_valid,
  input  logic [31:0] bpu_target,
  input  logic        pred_fail,
  input  logic [31:0] correct_pc,
  input  logic [1:0]  ex_entry_sel,
  input  logic [31:0] epc,
  input  logic [31:0] mem_pc,
  input  logic [31:0] except_vec,
  output logic [2:0]  pc_sel,
  output logic [31:0] next_pc,
  output logic        pc_we,
  output logic        flush_if,
  output logic        pending
`ifdef REDIRECT_PERF_CNT_EN
  ,
  output logic [NUM_PERF-1:0][31:0] perf_cnt
`endif
);
  state_e      state, state_nxt;
  pc_sel_e     pend_sel, pend_sel_nxt, live_sel, win_sel;
  logic [31:0] pend_addr, pend_addr_nxt, live_addr, win_addr;
  logic        take_live;
  pc_prio_enc u_prio (
    .cur_pc       (cur_pc),
    .bpu_valid    (bpu_valid),
    .bpu_target   (bpu_target),
    .pred_fail    (pred_fail),
    .correct_pc   (correct_pc),
    .ex_entry_sel (ex_entry_sel),
    .epc          (epc),
    .mem_pc       (mem_pc),
    .except_vec   (except_vec),
    .sel          (live_sel),
    .addr         (live_addr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_sel  <= SEL_PC4;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pend_sel  <= pend_sel_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end
  always_comb begin
    // a held redirect only yields to a strictly higher-priority live request
    take_live     = state == IDLE || sel_rank(live_sel) > sel_rank(pend_sel);
    win_sel       = take_live ? live_sel : pend_sel;
    win_addr      = take_live ? live_addr : pend_addr;
    state_nxt     = state;
    pend_sel_nxt  = pend_sel;
    pend_addr_nxt = pend_addr;
    if (state == IDLE) begin
      if (!pc_ready && is_redirect(live_sel)) begin
        state_nxt     = HOLD;
        pend_sel_nxt  = live_sel;
        pend_addr_nxt = live_addr;
      end
    end else if (pc_ready) begin
      state_nxt     = IDLE;
      pend_sel_nxt  = SEL_PC4;
      pend_addr_nxt = '0;
    end else begin
      pend_sel_nxt  = win_sel;
      pend_addr_nxt = win_addr;
    end
    pc_we    = !rst && pc_ready;
    flush_if = pc_we && is_redirect(win_sel);
    pending  = !rst && state == HOLD;
    pc_sel   = rst ? 3'd0 : win_sel;
    next_pc  = rst ? 32'd0 : win_addr;
  end
`ifdef REDIRECT_PERF_CNT_EN
  for (genvar i = 0; i < NUM_PERF; i++) begin : g_perf
    localparam pc_sel_e CLS = i == 0 ? SEL_EXCEPT :
                              i == 1 ? SEL_EPC    :
                              i == 2 ? SEL_MEMPC  :
                              i == 3 ? SEL_CORRECT : SEL_TARGET;
    always_ff @(posedge clk) begin
      if (rst) perf_cnt[i] <= '0;
      else if (pc_we && win_sel == CLS) perf_cnt[i] <= perf_cnt[i] + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: table-driven and sequence checks of pc_redirect_ctrl via an expected-value queue
module tb_pc_redirect_ctrl;
  localparam logic [31:0] TGT = 32'h8000_1000;
  localparam logic [31:0] CPC = 32'h8000_0100;
  localparam logic [31:0] MPC = 32'h8000_0300;
  localparam logic [31:0] EVC = 32'hBFC0_0380;
  localparam logic [31:0] EPA = 32'h8000_0200;
  localparam logic [31:0] EPB = 32'h8000_0280;
  typedef struct {
    logic        rst, rdy, bpu, pf;
    logic [1:0]  ex;
    logic [31:0] cur, ep;
    logic [2:0]  e_sel;
    logic [31:0] e_pc;
    logic        e_we, e_fl, e_pend;
  } vec_t;
  logic clk = 0, rst, pc_ready, bpu_valid, pred_fail, pc_we, flush_if, pending;
  logic [31:0] cur_pc, correct_pc, epc, mem_pc, except_vec, bpu_target, next_pc;
  logic [1:0] ex_entry_sel;
  logic [2:0] pc_sel;
`ifdef REDIRECT_PERF_CNT_EN
  logic [4:0][31:0] perf_cnt;
`endif
  int checks = 0, failures = 0;
  logic [37:0] exp_q[$];
  string name_q[$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .pc_ready(pc_ready), .cur_pc(cur_pc),
    .bpu_valid(bpu_valid), .bpu_target(bpu_target),
    .pred_fail(pred_fail), .correct_pc(correct_pc),
    .ex_entry_sel(ex_entry_sel), .epc(epc), .mem_pc(mem_pc), .except_vec(except_vec),
    .pc_sel(pc_sel), .next_pc(next_pc), .pc_we(pc_we), .flush_if(flush_if), .pending(pending)
`ifdef REDIRECT_PERF_CNT_EN
    , .perf_cnt(perf_cnt)
`endif
  );
  task automatic drive(input string nm, input vec_t v);
    logic [37:0] e, a;
    string n;
    rst = v.rst; pc_ready = v.rdy; bpu_valid = v.bpu; pred_fail = v.pf;
    ex_entry_sel = v.ex; cur_pc = v.cur; epc = v.ep;
    exp_q.push_back({v.e_sel, v.e_pc, v.e_we, v.e_fl, v.e_pend});
    name_q.push_back(nm);
    @(negedge clk);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a = {pc_sel, next_pc, pc_we, flush_if, pending};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got sel=%0d pc=%h we=%b fl=%b pend=%b, want sel=%0d pc=%h we=%b fl=%b pend=%b",
               n, a[37:35], a[34:3], a[2], a[1], a[0], e[37:35], e[34:3], e[2], e[1], e[0]);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    correct_pc = CPC; mem_pc = MPC; except_vec = EVC; bpu_target = TGT;
    tbl[0] = '{0,1,0,0,2'd0,32'h8000_0000,EPA, 3'd0,32'h8000_0004,1,0,0};
    tbl[1] = '{0,1,0,1,2'd3,32'h8000_0000,EPA, 3'd5,EVC,1,1,0};
    tbl[2] = '{0,1,1,0,2'd0,32'h8000_0000,EPA, 3'd1,TGT,1,0,0};
    tbl[3] = '{0,1,1,1,2'd0,32'h8000_0000,EPA, 3'd2,CPC,1,1,0};
    tbl[4] = '{0,1,1,1,2'd2,32'h8000_0000,EPA, 3'd4,MPC,1,1,0};
    tbl[5] = '{0,1,1,1,2'd1,32'h8000_0000,EPA, 3'd3,EPA,1,1,0};
    tbl[6] = '{0,1,0,0,2'd0,32'hFFFF_FFFC,EPA, 3'd0,32'h0,1,0,0};
    tbl[7] = '{0,0,1,0,2'd0,32'h8000_0000,EPA, 3'd1,TGT,0,0,0};
    drive("reset0", '{1,1,1,1,2'd3,32'h10,EPA, 3'd0,32'h0,0,0,0});
    drive("reset1", '{1,1,0,1,2'd0,32'h10,EPA, 3'd0,32'h0,0,0,0});
    for (int i = 0; i < 8; i++) drive($sformatf("vec%0d", i), tbl[i]);
    drive("c3_latch", '{0,0,1,1,2'd0,32'h8000_0000,EPA, 3'd2,CPC,0,0,0});
    for (int i = 0; i < 3; i++) drive($sformatf("c3_hold%0d", i), '{0,0,1,0,2'd0,32'h8000_0000,EPA, 3'd2,CPC,0,0,1});
    drive("c3_release", '{0,1,1,0,2'd0,32'h8000_0000,EPA, 3'd2,CPC,1,1,1});
    drive("c3_after", '{0,1,1,0,2'd0,32'h8000_0000,EPA, 3'd1,TGT,1,0,0});
    drive("c4_latch", '{0,0,0,1,2'd0,32'h8000_0000,EPA, 3'd2,CPC,0,0,0});
    drive("c4_over", '{0,0,0,0,2'd1,32'h8000_0000,EPA, 3'd3,EPA,0,0,1});
    drive("c4_held", '{0,0,1,0,2'd0,32'h8000_0000,EPB, 3'd3,EPA,0,0,1});
    drive("c4_release", '{0,1,0,0,2'd0,32'h8000_0000,EPB, 3'd3,EPA,1,1,1});
    drive("c5_latch", '{0,0,0,0,2'd1,32'h8000_0000,EPA, 3'd3,EPA,0,0,0});
    drive("c5_lower", '{0,0,0,1,2'd0,32'h8000_0000,EPA, 3'd3,EPA,0,0,1});
    drive("c5_equal", '{0,0,0,0,2'd1,32'h8000_0000,EPB, 3'd3,EPA,0,0,1});
    drive("c5_higher", '{0,0,0,0,2'd3,32'h8000_0000,EPB, 3'd5,EVC,0,0,1});
    drive("c5_release", '{0,1,0,1,2'd2,32'h8000_0000,EPB, 3'd5,EVC,1,1,1});
    drive("c6_latch", '{0,0,0,1,2'd0,32'h8000_0000,EPA, 3'd2,CPC,0,0,0});
    drive("c6_hold", '{0,0,0,0,2'd0,32'h8000_0000,EPA, 3'd2,CPC,0,0,1});
    drive("c6_rst", '{1,0,0,0,2'd0,32'h8000_0000,EPA, 3'd0,32'h0,0,0,0});
    drive("c6_idle", '{0,0,0,0,2'd0,32'h8000_0000,EPA, 3'd0,32'h8000_0004,0,0,0});
    drive("c6_pc4", '{0,1,0,0,2'd0,32'h8000_0040,EPA, 3'd0,32'h8000_0044,1,0,0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-003 SHALL have port pc_ready, input, 1, PC register may update this cycle (IF not stalled).
REQ-004 SHALL have port cur_pc, input, 32, current fetch PC.
REQ-005 SHALL have ports bpu_valid (input, 1) and bpu_target (input, 32): taken prediction for cur_pc.
REQ-006 SHALL have ports pred_fail (input, 1) and correct_pc (input, 32): EX mispredict and its repair address.
REQ-007 SHALL have ports ex_entry_sel (input, 2), epc (input, 32), mem_pc (input, 32) and except_vec (input, 32).
REQ-008 SHALL have port pc_sel, output, 3, selected next-PC class.
REQ-009 SHALL have port next_pc, output, 32, resolved next PC.
REQ-010 SHALL have port pc_we, output, 1, PC register write enable.
REQ-011 SHALL have ports flush_if (output, 1), kill in-flight fetch, and pending (output, 1), redirect held.

Function
REQ-012 SHALL use encodings: pc_sel PC4=0, Target=1, Correct=2, EPC=3, MEMPC=4, Except=5; ex_entry_sel None=0, Eret=1, Refetch=2, Except=3.
REQ-013 SHALL resolve a live request by fixed priority: Except > Eret (EPC) > Refetch (MEMPC) > pred_fail (Correct) > bpu_valid (Target) > PC4 (cur_pc+4, mod 2^32).
REQ-014 SHALL treat classes 2..5 as redirects and classes 0..1 as sequential.
REQ-015 SHALL use an FSM with states IDLE and HOLD; reset state IDLE.
REQ-016 IDLE, pc_ready=1: SHALL drive the live winner on pc_sel/next_pc with pc_we=1, zero latency.
REQ-017 IDLE, pc_ready=0, live redirect: SHALL latch its class and address into the pending register, go to HOLD, pc_we=0.
REQ-018 IDLE, pc_ready=0, no redirect: SHALL keep pc_we=0 and latch nothing.
REQ-019 HOLD: SHALL drive the pending class/address and assert pending=1, overriding live Target/PC4.
REQ-020 HOLD, new live redirect of strictly higher priority: SHALL overwrite the pending register in that cycle; equal or lower priority SHALL be ignored.
REQ-021 HOLD, pc_ready=1: SHALL apply the winner of pending vs. live (per REQ-020) with pc_we=1 and return to IDLE next cycle.
REQ-022 SHALL assert flush_if for exactly the cycle pc_we=1 with a redirect class, and never for PC4/Target.
REQ-023 Combinational outputs SHALL settle in the same cycle as their inputs.

Reset
REQ-024 On rst=1, SHALL set state IDLE, pending register cleared (class PC4, address 0), pending=0 and counters 0.
REQ-025 Output values during rst=1 SHALL be pc_we=0, flush_if=0, pending=0, pc_sel=0, next_pc=0.
REQ-026 rst asserted in HOLD SHALL discard the held redirect.

Configuration
REQ-027 With REDIRECT_PERF_CNT_EN defined, SHALL add five 32-bit wrapping counters (Except, Eret, Refetch, Correct, Target), each incremented on every pc_we=1 cycle of that class, exposed as output perf_cnt[4:0][31:0].
REQ-028 Without REDIRECT_PERF_CNT_EN, SHALL have no counters and no perf_cnt port; all other behaviour identical.

Structure
REQ-029 pc_sel and ex_entry_sel encodings and the FSM state enum SHALL live in the shared CPU package.
REQ-030 Priority resolution SHALL be a sub-module pc_prio_enc (pure combinational: requests in, class plus address out), instantiated once.

Verification
REQ-031 Case 1: pc_ready=1, cur_pc=0x8000_0000, no requests -> pc_sel=0, next_pc=0x8000_0004, pc_we=1, flush_if=0.
REQ-032 Case 2: pc_ready=1, ex_entry_sel=3, pred_fail=1, except_vec=0xBFC0_0380 -> pc_sel=5, next_pc=0xBFC0_0380, flush_if=1.
REQ-033 Case 3: pc_ready=0, pred_fail=1, correct_pc=0x8000_0100, hold 3 cycles with bpu_valid=1, then pc_ready=1 -> pending=1 for 3 cycles, then pc_sel=2, next_pc=0x8000_0100, pc_we=1, next cycle pending=0.
REQ-034 Case 4: in HOLD with Correct, ex_entry_sel=1, epc=0x8000_0200 -> pending overwritten; on release pc_sel=3, next_pc=0x8000_0200.
REQ-035 Case 5: in HOLD with Eret, pred_fail=1 -> pending unchanged (Eret kept).
REQ-036 Case 6: rst=1 asserted while in HOLD -> next cycle pending=0, state IDLE, and after rst deasserts PC4 flow resumes.
